// File: rtl/mvu_pe_pipe.sv
// MVU processing element: SIMD multiply lanes, a registered adder tree and a
// fold accumulator. Beats enter on a valid/ready handshake, results leave on
// one. A result that is not taken holds the whole pipe.
// Optional build macro MVU_PE_SAT_EN: the accumulator saturates instead of
// wrapping, and out_ovf flags any saturation in the group. In the default
// build out_ovf is tied low.
module mvu_pe_pipe #(
  parameter int         SIMD   = 4,
  parameter int         TSrcI  = 4,
  parameter int         TW     = 4,
  parameter int         TDstI  = 16,
  parameter int         SF     = 8,
  parameter logic [1:0] OP_SGN = 2'b00
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [TSrcI*SIMD-1:0]   in_act,
  input  logic [TW*SIMD-1:0]      in_wgt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TDstI-1:0]        out,
  output logic                    out_ovf
);

  // D registered tree levels; lanes are zero-padded up to NP = 2**D.
  localparam int D  = (SIMD > 1) ? $clog2(SIMD) : 0;
  localparam int NP = 1 << D;
  // Each operand gets one extra bit so the product is always a signed multiply.
  localparam int PW = TSrcI + TW + 2;
  localparam int CW = (SF > 1) ? $clog2(SF) : 1;

`ifdef MVU_PE_SAT_EN
  // The tree is wide enough to be exact; only the accumulator clips.
  localparam int  TREE_W = ((TDstI > PW) ? TDstI : PW) + D;
  localparam int  AW     = TREE_W + 2;
  localparam bit  SGN    = (OP_SGN != 2'b00);
  localparam logic signed [AW-1:0] ONE  = AW'(1);
  localparam logic signed [AW-1:0] MAXV = SGN ? ((ONE <<< (TDstI - 1)) - ONE)
                                              : ((ONE <<< TDstI) - ONE);
  localparam logic signed [AW-1:0] MINV = SGN ? -(ONE <<< (TDstI - 1)) : '0;
`else
  localparam int  TREE_W = TDstI;
`endif

  function automatic logic signed [TSrcI:0] ext_act(input logic [TSrcI-1:0] a);
    ext_act = {OP_SGN[0] & a[TSrcI-1], a};
  endfunction

  function automatic logic signed [TW:0] ext_wgt(input logic [TW-1:0] w);
    ext_wgt = {OP_SGN[1] & w[TW-1], w};
  endfunction

`ifdef MVU_PE_SAT_EN
  // Accumulator value re-read in the signedness of the result range.
  function automatic logic signed [AW-1:0] acc_widen(input logic [TDstI-1:0] a);
    acc_widen = {{(AW - TDstI){SGN & a[TDstI-1]}}, a};
  endfunction

  // Returns {clipped, value} with value clamped to the TDstI result range.
  function automatic logic [TDstI:0] sat_acc(input logic signed [AW-1:0] v);
    if (v > MAXV)      sat_acc = {1'b1, MAXV[TDstI-1:0]};
    else if (v < MINV) sat_acc = {1'b1, MINV[TDstI-1:0]};
    else               sat_acc = {1'b0, v[TDstI-1:0]};
  endfunction
`endif

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  logic [CW-1:0] fold_cnt;
  logic          beat_last;
  assign beat_last = (fold_cnt == CW'(SF - 1));

  // Fold counter: position of the next accepted beat within its group.
  always_ff @(posedge clock) begin
    if (reset) begin
      fold_cnt <= '0;
    end else if (in_valid & in_ready) begin
      fold_cnt <= beat_last ? '0 : fold_cnt + 1'b1;
    end
  end

  // Per-lane products, padding lanes forced to zero.
  logic [NP*PW-1:0] prod_flat;
  for (genvar i = 0; i < NP; i++) begin : g_lane
    if (i < SIMD) begin : g_mul
      assign prod_flat[i*PW +: PW] = PW'(ext_act(in_act[i*TSrcI +: TSrcI]))
                                   * PW'(ext_wgt(in_wgt[i*TW +: TW]));
    end else begin : g_pad
      assign prod_flat[i*PW +: PW] = '0;
    end
  end

  // Control tags: stage 0 is the product register, stage k the k-th tree level.
  logic vld_p  [0:D];
  logic last_p [0:D];

  // Valid/last tags ride alongside the data and hold on stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k <= D; k++) begin
        vld_p[k]  <= 1'b0;
        last_p[k] <= 1'b0;
      end
    end else if (!stall) begin
      vld_p[0]  <= in_valid;
      last_p[0] <= beat_last;
      for (int k = 1; k <= D; k++) begin
        vld_p[k]  <= vld_p[k-1];
        last_p[k] <= last_p[k-1];
      end
    end
  end

  for (genvar k = 0; k <= D; k++) begin : g_lvl
    localparam int N = NP >> k;
    logic signed [TREE_W-1:0] node [0:N-1];
    if (k == 0) begin : g_leaf
      // Stage p0: register the extended lane products.
      always_ff @(posedge clock) begin
        if (!stall) begin
          for (int j = 0; j < N; j++) begin
            node[j] <= TREE_W'(signed'(prod_flat[j*PW +: PW]));
          end
        end
      end
    end else begin : g_add
      // Stage p<k>: pairwise sums of the previous level.
      always_ff @(posedge clock) begin
        if (!stall) begin
          for (int j = 0; j < N; j++) begin
            node[j] <= g_lvl[k-1].node[2*j] + g_lvl[k-1].node[2*j+1];
          end
        end
      end
    end
  end

  logic signed [TREE_W-1:0] tree_sum;
  assign tree_sum = g_lvl[D].node[0];

  logic [TDstI-1:0] acc;
  logic [TDstI-1:0] acc_nxt;
  logic             acc_first;

`ifdef MVU_PE_SAT_EN
  logic               acc_ovf;
  logic               ovf_nxt;
  logic signed [AW-1:0] acc_tot;
  logic [TDstI:0]     sat_res;

  assign acc_tot = (acc_first ? '0 : acc_widen(acc)) + AW'(tree_sum);
  assign sat_res = sat_acc(acc_tot);
  assign acc_nxt = sat_res[TDstI-1:0];
  assign ovf_nxt = (acc_first ? 1'b0 : acc_ovf) | sat_res[TDstI];

  // Overflow flag: sticky across a group, presented with the result.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_ovf <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      if (out_valid & out_ready) begin
        out_ovf <= 1'b0;
      end
      if (!stall && vld_p[D]) begin
        if (last_p[D]) begin
          out_ovf <= ovf_nxt;
          acc_ovf <= 1'b0;
        end else begin
          acc_ovf <= ovf_nxt;
        end
      end
    end
  end
`else
  assign acc_nxt = acc_first ? tree_sum : acc + tree_sum;
  assign out_ovf = 1'b0;
`endif

  // Accumulator stage: load on beat 0, add otherwise, publish on the last beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc       <= '0;
      acc_first <= 1'b1;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
      if (!stall && vld_p[D]) begin
        if (last_p[D]) begin
          out       <= acc_nxt;
          out_valid <= 1'b1;
          acc       <= '0;
          acc_first <= 1'b1;
        end else begin
          acc       <= acc_nxt;
          acc_first <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mvu_pe_pipe.sv
// Directed bench for mvu_pe_pipe: four instances cover unsigned folding,
// signed lanes, backpressure, reset mid-group, odd SIMD with bubbles and
// accumulator overflow.
module tb_mvu_pe_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  // a: SIMD=4, SF=2, unsigned
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [15:0] a_in_act, a_in_wgt, a_out;
  // b: SIMD=4, SF=1, signed both
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [15:0] b_in_act, b_in_wgt, b_out;
  // c: SIMD=4, SF=8, TDstI=8, unsigned
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf;
  logic [15:0] c_in_act, c_in_wgt;
  logic [7:0]  c_out;
  // d: SIMD=3, SF=4, unsigned
  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_ovf;
  logic [11:0] d_in_act, d_in_wgt;
  logic [15:0] d_out;

  mvu_pe_pipe #(.SIMD(4), .TSrcI(4), .TW(4), .TDstI(16), .SF(2), .OP_SGN(2'b00)) u_a (
    .clock(clk), .reset(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_act(a_in_act), .in_wgt(a_in_wgt), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out(a_out), .out_ovf(a_out_ovf));

  mvu_pe_pipe #(.SIMD(4), .TSrcI(4), .TW(4), .TDstI(16), .SF(1), .OP_SGN(2'b11)) u_b (
    .clock(clk), .reset(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_act(b_in_act), .in_wgt(b_in_wgt), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out(b_out), .out_ovf(b_out_ovf));

  mvu_pe_pipe #(.SIMD(4), .TSrcI(4), .TW(4), .TDstI(8), .SF(8), .OP_SGN(2'b00)) u_c (
    .clock(clk), .reset(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_act(c_in_act), .in_wgt(c_in_wgt), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out(c_out), .out_ovf(c_out_ovf));

  mvu_pe_pipe #(.SIMD(3), .TSrcI(4), .TW(4), .TDstI(16), .SF(4), .OP_SGN(2'b00)) u_d (
    .clock(clk), .reset(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_act(d_in_act), .in_wgt(d_in_wgt), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out(d_out), .out_ovf(d_out_ovf));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  int acc_n, got_n, early;
  logic saw_stall;
  logic [7:0] sat_out_exp;
  logic       sat_ovf_exp;

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_act = '0; a_in_wgt = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_act = '0; b_in_wgt = '0; b_out_ready = 1;
    c_in_valid = 0; c_in_act = '0; c_in_wgt = '0; c_out_ready = 1;
    d_in_valid = 0; d_in_act = '0; d_in_wgt = '0; d_out_ready = 1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out", a_out, 0);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_c_out_ovf", c_out_ovf, 0);
    check("rst_d_out_valid", d_out_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    // unsigned basic: two beats of 3*2 over four lanes -> 48, four cycles later
    a_in_valid = 1; a_in_act = 16'h3333; a_in_wgt = 16'h2222;
    @(negedge clk);
    @(negedge clk);
    a_in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("basic_not_yet", a_out_valid, 0);
    @(negedge clk);
    check("basic_valid", a_out_valid, 1);
    check("basic_out", a_out, 16'd48);
    @(negedge clk);
    check("basic_cleared", a_out_valid, 0);

    // signed lanes, one result per beat
    b_in_valid = 1; b_in_act = 16'hFFFF; b_in_wgt = 16'h7777;
    @(negedge clk);
    b_in_act = 16'h8123; b_in_wgt = 16'h7F12;
    @(negedge clk);
    b_in_act = 16'hFFFF; b_in_wgt = 16'h7777;
    @(negedge clk);
    b_in_valid = 0;
    @(negedge clk);
    check("sgn0_valid", b_out_valid, 1);
    check("sgn0_out", b_out, 16'hFFE4);
    @(negedge clk);
    check("sgn1_valid", b_out_valid, 1);
    check("sgn1_out", b_out, 16'hFFCF);
    @(negedge clk);
    check("sgn2_valid", b_out_valid, 1);
    check("sgn2_out", b_out, 16'hFFE4);
    @(negedge clk);
    check("sgn_cleared", b_out_valid, 0);

    // backpressure: six beats offered back to back, sink stalls early on
    acc_n = 0; got_n = 0; saw_stall = 0;
    a_in_act = 16'h3333; a_in_wgt = 16'h2222;
    for (int cyc = 0; cyc < 80; cyc++) begin
      a_out_ready = (cyc >= 10);
      a_in_valid  = (acc_n < 6);
      #1;
      if (a_out_valid && !a_out_ready) check("bp_hold", a_out, 16'd48);
      if (a_out_valid && a_out_ready) begin
        check("bp_out", a_out, 16'd48);
        got_n++;
      end
      if (!a_in_ready) saw_stall = 1;
      if (a_in_valid && a_in_ready) acc_n++;
      if (got_n == 3) break;
      @(negedge clk);
    end
    a_in_valid = 0; a_out_ready = 1;
    check("bp_results", got_n, 3);
    check("bp_accepted", acc_n, 6);
    check("bp_stalled", saw_stall, 1);
    @(negedge clk);
    check("bp_drained", a_out_valid, 0);

    // reset mid-group discards three accepted beats
    c_in_valid = 1; c_in_act = 16'h1111; c_in_wgt = 16'h1111;
    repeat (3) @(negedge clk);
    c_in_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid_rst_valid", c_out_valid, 0);
    early = 0;
    c_in_valid = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (c_out_valid) early++;
      @(negedge clk);
    end
    c_in_valid = 0;
    for (int k = 0; k < 20; k++) begin
      if (c_out_valid) break;
      @(negedge clk);
    end
    check("mid_rst_early", early, 0);
    check("mid_rst_done", c_out_valid, 1);
    check("mid_rst_out", c_out, 8'h20);
    check("mid_rst_ovf", c_out_ovf, 0);
    @(negedge clk);

    // accumulator overflow: 8 beats of 4 x 15*15
`ifdef MVU_PE_SAT_EN
    sat_out_exp = 8'hFF; sat_ovf_exp = 1'b1;
`else
    sat_out_exp = 8'h20; sat_ovf_exp = 1'b0;
`endif
    c_in_valid = 1; c_in_act = 16'hFFFF; c_in_wgt = 16'hFFFF;
    repeat (8) @(negedge clk);
    c_in_valid = 0;
    for (int k = 0; k < 20; k++) begin
      if (c_out_valid) break;
      @(negedge clk);
    end
    check("ovf_done", c_out_valid, 1);
    check("ovf_out", c_out, sat_out_exp);
    check("ovf_flag", c_out_ovf, sat_ovf_exp);
    @(negedge clk);
    check("ovf_flag_clear", c_out_ovf, 0);

    // odd SIMD with bubbles: four real beats of 3 -> 12
    early = 0;
    d_in_act = 12'h111; d_in_wgt = 12'h111;
    for (int k = 0; k < 8; k++) begin
      d_in_valid = (k % 2 == 0);
      #1;
      if (d_out_valid) early++;
      @(negedge clk);
    end
    d_in_valid = 0;
    for (int k = 0; k < 20; k++) begin
      if (d_out_valid) break;
      @(negedge clk);
    end
    check("bub_early", early, 0);
    check("bub_done", d_out_valid, 1);
    check("bub_out", d_out, 16'd12);
    @(negedge clk);
    check("bub_cleared", d_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
